// File: rtl/bmp_pkg.sv
// Shared types and constants for the BMP stream writer: header size, FSM states
// and the byte-lane positions inside a 32-bit pixel word.
package bmp_pkg;

    localparam int HDR_BYTES_DEF = 54;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        WAIT,
        DATA,
        DONE
    } state_e;

    localparam logic [1:0] LANE_FIRST = 2'd0;
    localparam logic [1:0] LANE_PF    = 2'd2;
    localparam logic [1:0] LANE_LAST  = 2'd3;

    // Pixel words leave the block least-significant byte first.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bmp_hdr_regs.sv
// Software-loaded BMP header storage: one byte per entry, cleared on reset,
// single write port and a combinational read port.
module bmp_hdr_regs #(
    parameter int HDR_BYTES = 54
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en_i,
    input  logic [5:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic [5:0] rd_addr_i,
    output logic [7:0] rd_data_o
);

    logic [7:0] mem_q [HDR_BYTES];

    // Out-of-range addresses are silently ignored on write and read back as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HDR_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en_i && (wr_addr_i < 6'(HDR_BYTES))) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = (rd_addr_i < 6'(HDR_BYTES)) ? mem_q[rd_addr_i] : 8'h00;

endmodule

// File: rtl/bmp_stream_writer.sv
// Drains pixel words from the highlight FIFO behind a software-loaded BMP header
// as a registered valid/ready byte stream. Optional macro: BMP_WRITER_PREFETCH_EN.
module bmp_stream_writer
    import bmp_pkg::*;
#(
    parameter int HDR_BYTES = HDR_BYTES_DEF,
    parameter int CNT_W     = 20,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hdr_wr_en,
    input  logic [5:0]        hdr_addr,
    input  logic [7:0]        hdr_din,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [5:0] HDR_LAST = 6'(HDR_BYTES - 1);

    state_e            state_q, state_d;
    logic [5:0]        byte_idx_q, byte_idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [CNT_W-1:0]  words_left_q, words_left_d;
    logic [31:0]       word_q, word_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic [5:0]        hdrRdIdx;
    logic [7:0]        hdrRdData;
    logic [7:0]        hdrByte;
    logic              handshake;
    logic              pfIssue;
    logic              pfCapture;
    logic              nextAvail;
    logic [31:0]       nextWord;

    bmp_hdr_regs #(.HDR_BYTES(HDR_BYTES)) u_hdr_regs (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (hdr_wr_en && (state_q == IDLE)),
        .wr_addr_i (hdr_addr),
        .wr_data_i (hdr_din),
        .rd_addr_i (hdrRdIdx),
        .rd_data_o (hdrRdData)
    );

    // The output register is loaded one byte ahead, so the read index is the byte to present next.
    assign hdrRdIdx  = (state_q == IDLE) ? 6'd0 : byte_idx_q + 6'd1;
    assign hdrByte   = ((state_q == IDLE) && hdr_wr_en && (hdr_addr == 6'd0)) ? hdr_din : hdrRdData;
    assign handshake = out_valid_q && out_ready;

`ifdef BMP_WRITER_PREFETCH_EN
    logic [31:0] hold_q;
    logic        hold_valid_q;
    logic        pf_pend_q;

    assign pfIssue   = (state_q == DATA) && (lane_q == LANE_PF) && (words_left_q != '0) &&
                       !fifo_empty && !pf_pend_q && !hold_valid_q;
    assign pfCapture = pf_pend_q;
    assign nextAvail = pf_pend_q || hold_valid_q;
    assign nextWord  = pf_pend_q ? fifo_dout : hold_q;

    // A popped word lands one cycle after the pop; keep it until the current word's last byte leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            pf_pend_q    <= 1'b0;
        end else begin
            pf_pend_q <= pfIssue;
            if (pf_pend_q) begin
                hold_q <= fifo_dout;
            end
            if ((state_q == DATA) && (lane_q == LANE_LAST) && handshake) begin
                hold_valid_q <= 1'b0;
            end else if (pf_pend_q) begin
                hold_valid_q <= 1'b1;
            end
        end
    end
`else
    assign pfIssue   = 1'b0;
    assign pfCapture = 1'b0;
    assign nextAvail = 1'b0;
    assign nextWord  = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            lane_q       <= '0;
            words_left_q <= '0;
            word_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            lane_q       <= lane_d;
            words_left_q <= words_left_d;
            word_q       <= word_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        lane_d       = lane_q;
        words_left_d = words_left_q;
        word_d       = word_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        fifo_rd_en   = 1'b0;

        if (pfCapture) begin
            words_left_d = words_left_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    words_left_d = num_words;
                    byte_idx_d   = '0;
                    out_valid_d  = 1'b1;
                    out_data_d   = hdrByte;
                    out_last_d   = (HDR_LAST == 6'd0) && (num_words == '0);
                    state_d      = HDR;
                end
            end
            HDR: begin
                if (handshake) begin
                    if (byte_idx_q == HDR_LAST) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = (words_left_q == '0) ? DONE : FETCH;
                    end else begin
                        byte_idx_d = byte_idx_q + 6'd1;
                        out_data_d = hdrByte;
                        out_last_d = (hdrRdIdx == HDR_LAST) && (words_left_q == '0);
                    end
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                word_d       = fifo_dout;
                words_left_d = words_left_q - CNT_W'(1);
                lane_d       = LANE_FIRST;
                out_valid_d  = 1'b1;
                out_data_d   = lane_byte(fifo_dout, LANE_FIRST);
                out_last_d   = 1'b0;
                state_d      = DATA;
            end
            DATA: begin
                fifo_rd_en = pfIssue;
                if (handshake) begin
                    if (lane_q != LANE_LAST) begin
                        lane_d     = lane_q + 2'd1;
                        out_data_d = lane_byte(word_q, lane_q + 2'd1);
                        out_last_d = (lane_q == LANE_PF) && (words_left_q == '0);
                    end else if (nextAvail) begin
                        word_d     = nextWord;
                        lane_d     = LANE_FIRST;
                        out_data_d = lane_byte(nextWord, LANE_FIRST);
                        out_last_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = (words_left_q != '0) ? FETCH : DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: doc/bmp_stream_writer.md
# bmp_stream_writer

Sink-side drain for the motion-detect pipeline. Pops 32-bit highlighted pixel words from the highlight output FIFO, prepends a software-loaded BMP header, and emits the complete BMP file as a byte stream over a valid/ready interface (toward a file writer, DMA or UART). It is the hardware counterpart of the FIFO pushers that feed the pipeline.

## Interface
- HDR_BYTES, 54: BMP header length in bytes.
- CNT_W, 20: width of the pixel-word count.
- DATA_W, 32: FIFO word width; must be 32 (4 bytes per word).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- hdr_wr_en  in  1  write one header byte.
- hdr_addr  in  6  header byte index, 0..HDR_BYTES-1; larger values are ignored.
- hdr_din  in  8  header byte value.
- start  in  1  one-cycle pulse that begins a frame; accepted only in IDLE.
- num_words  in  CNT_W  pixel words to drain; latched on an accepted start.
- fifo_empty  in  1  highlight FIFO empty.
- fifo_rd_en  out  1  pop request.
- fifo_dout  in  DATA_W  FIFO data, valid the cycle after fifo_rd_en.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8  stream byte.
- out_last  out  1  marks the final byte of the file.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- States: IDLE, HDR, FETCH, WAIT, DATA, DONE.
- IDLE:
  - Header register writes are accepted only in IDLE; writes in any other state are dropped.
  - An accepted start latches num_words into words_left, clears byte_idx, and moves to HDR.
- HDR: emits header[byte_idx] for byte_idx 0..HDR_BYTES-1, one byte per accepted handshake.
  - After byte HDR_BYTES-1 is accepted, go to DONE if words_left==0, otherwise to FETCH.
- FETCH: assert fifo_rd_en for exactly one cycle when !fifo_empty, then go to WAIT. Stall in FETCH while the FIFO is empty.
- WAIT: capture fifo_dout into word_reg, decrement words_left, go to DATA.
- DATA: emit word_reg bytes LSB-first (bits [7:0], [15:8], [23:16], [31:24]).
  - After the 4th byte is accepted, go to FETCH if words_left!=0, otherwise to DONE.
- DONE: pulse done for one cycle, then return to IDLE.
- out_last is high with the final byte:
  - header byte 53 when num_words==0;
  - otherwise byte 3 of the last word.
- start is ignored while busy.
- fifo_rd_en is never asserted while fifo_empty is high.

## Timing
- Reset values:
  - outputs: out_valid=0, out_data=0, out_last=0, fifo_rd_en=0, busy=0, done=0;
  - internal: state=IDLE, all header bytes=0x00, counters=0.
- Reset asserted mid-frame aborts immediately; no partial bytes are emitted after release.
- Output is registered. While out_valid && !out_ready, out_data and out_last hold stable.
- First header byte is valid 1 cycle after the accepted start.
- Without prefetch: 6 cycles per word at a constant out_ready=1 (FETCH, WAIT, 4×DATA).
- A header write in the same cycle as an accepted start still lands, because both occur in IDLE.
- words_left is CNT_W bits wide. num_words up to 2^CNT_W-1 is supported, with no wrap.

## Configuration
- BMP_WRITER_PREFETCH_EN:
  - Defined: during DATA byte 2, if words_left!=0 and !fifo_empty, issue fifo_rd_en and capture into a one-word holding register. The next word then streams back-to-back, giving 1 byte/cycle sustained. If the FIFO is empty at that point, fall back to FETCH.
  - Undefined: the FETCH/WAIT sequence is used for every word.
- Byte order and out_last behave identically in both builds.

## Structure
- bmp_pkg holds:
  - the HDR_BYTES default;
  - the state enum (IDLE, HDR, FETCH, WAIT, DATA, DONE);
  - byte-lane index constants.
- Sub-module bmp_hdr_regs: HDR_BYTES×8 register file with asynchronous reset, a write port, and a combinational read port indexed by byte_idx.

## Test plan
- Header load: write bytes 0x42, 0x4D, then 0x00 for the rest, start with num_words=0. Expect 54 bytes, the first two 0x42, 0x4D, out_last on byte 53, done 1 cycle later, and fifo_rd_en never asserted.
- Single word: FIFO holds 0xDDCCBBAA, num_words=1, out_ready=1. Expect the header followed by AA, BB, CC, DD, with out_last on DD.
- Backpressure: toggle out_ready every cycle over 3 words. Expect every byte exactly once, with data held stable while stalled.
- Empty stall: FIFO empty for 20 cycles after the header, then 2 words arrive. Expect no rd_en during the empty cycles, and correct bytes after.
- Abort: assert reset during DATA byte 1 of word 5. Expect all outputs at reset values, the header cleared to 0, and a subsequent frame correct.
- Prefetch build: 100 words, FIFO pre-filled, out_ready=1. Expect 400 data bytes in exactly 400 consecutive cycles after the header.
